// File: rtl/block_draw_ctrl_if.sv
// Command and pixel bus between the game FSM (master) and block_draw_ctrl (slave).
// Carries rectangle/clear requests in and the single-pixel write stream out.
// Optional feature macro: DRAW_OUTLINE_EN adds req_outline.
interface block_draw_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic       clear_req;
`ifdef DRAW_OUTLINE_EN
  logic       req_outline;
`endif
  logic       busy;
  logic       done;
  logic [7:0] xout;
  logic [6:0] yout;
  logic [2:0] colourout;
  logic       plot;

`ifdef DRAW_OUTLINE_EN
  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour, clear_req, req_outline,
    input  req_ready, busy, done, xout, yout, colourout, plot
  );
  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour, clear_req, req_outline,
    output req_ready, busy, done, xout, yout, colourout, plot
  );
`else
  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour, clear_req,
    input  req_ready, busy, done, xout, yout, colourout, plot
  );
  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour, clear_req,
    output req_ready, busy, done, xout, yout, colourout, plot
  );
`endif
endinterface

// File: rtl/block_draw_ctrl.sv
// Purpose: turns one rectangle/clear command into a raster stream of single-pixel writes.
// Latency: first pixel one cycle after accept, one pixel per cycle, done one cycle after last pixel.
// Backpressure: req_ready high only in IDLE; commands wait until the previous one finishes.
// Optional feature macro: DRAW_OUTLINE_EN (plot only the perimeter of outline rectangles).
module block_draw_ctrl #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input logic              clk,
  input logic              reset_n,
  block_draw_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);

  state_t     state, state_nx;
  logic [7:0] x0, x0_nx;
  logic [7:0] x_last, x_last_nx;
  logic [6:0] y_last, y_last_nx;
  logic [7:0] xout_nx;
  logic [6:0] yout_nx;
  logic [2:0] colour_nx;
  logic       plot_nx;
`ifdef DRAW_OUTLINE_EN
  logic [6:0] y0, y0_nx;
  logic       outline, outline_nx;
`endif

  logic [8:0] req_x9, req_y9, rem_w, rem_h, w_eff, h_eff;
  logic [7:0] clip_x_last;
  logic [6:0] clip_y_last;
  logic       empty;

  // Clip the incoming rectangle to the screen; 9 bits so edge sums never wrap.
  always_comb begin
    req_x9      = {1'b0, bus.req_x};
    req_y9      = {2'b00, bus.req_y};
    rem_w       = SW9 - req_x9;
    rem_h       = SH9 - req_y9;
    w_eff       = ({1'b0, bus.req_w} < rem_w) ? {1'b0, bus.req_w} : rem_w;
    h_eff       = ({2'b00, bus.req_h} < rem_h) ? {2'b00, bus.req_h} : rem_h;
    empty       = (req_x9 >= SW9) || (req_y9 >= SH9) || (bus.req_w == 8'd0) || (bus.req_h == 7'd0);
    clip_x_last = 8'(req_x9 + w_eff - 9'd1);
    clip_y_last = 7'(req_y9 + h_eff - 9'd1);
  end

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_nx  = state;
    x0_nx     = x0;
    x_last_nx = x_last;
    y_last_nx = y_last;
    xout_nx   = bus.xout;
    yout_nx   = bus.yout;
    colour_nx = bus.colourout;
    plot_nx   = 1'b0;
`ifdef DRAW_OUTLINE_EN
    y0_nx      = y0;
    outline_nx = outline;
`endif
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          x0_nx     = 8'd0;
          x_last_nx = 8'(SCREEN_W - 1);
          y_last_nx = 7'(SCREEN_H - 1);
          xout_nx   = 8'd0;
          yout_nx   = 7'd0;
          colour_nx = CLEAR_COLOUR;
          plot_nx   = 1'b1;
          state_nx  = DRAW;
`ifdef DRAW_OUTLINE_EN
          y0_nx      = 7'd0;
          outline_nx = 1'b0;
`endif
        end else if (bus.req_valid) begin
          if (empty) begin
            state_nx = DONE;
          end else begin
            x0_nx     = bus.req_x;
            x_last_nx = clip_x_last;
            y_last_nx = clip_y_last;
            xout_nx   = bus.req_x;
            yout_nx   = bus.req_y;
            colour_nx = bus.req_colour;
            plot_nx   = 1'b1;  // top-left corner is always on the perimeter
            state_nx  = DRAW;
`ifdef DRAW_OUTLINE_EN
            y0_nx      = bus.req_y;
            outline_nx = bus.req_outline;
`endif
          end
        end
      end
      DRAW: begin
        if (bus.xout == x_last) begin
          if (bus.yout == y_last) begin
            state_nx = DONE;
          end else begin
            xout_nx = x0;
            yout_nx = bus.yout + 7'd1;
            plot_nx = 1'b1;
          end
        end else begin
          xout_nx = bus.xout + 8'd1;
          plot_nx = 1'b1;
        end
`ifdef DRAW_OUTLINE_EN
        // Interior pixels are still walked so timing matches a filled draw.
        if (plot_nx && outline)
          plot_nx = (xout_nx == x0) || (xout_nx == x_last) ||
                    (yout_nx == y0) || (yout_nx == y_last);
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched command and registered adapter outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      x0            <= 8'd0;
      x_last        <= 8'd0;
      y_last        <= 7'd0;
      bus.xout      <= 8'd0;
      bus.yout      <= 7'd0;
      bus.colourout <= 3'd0;
      bus.plot      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
`ifdef DRAW_OUTLINE_EN
      y0            <= 7'd0;
      outline       <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      x0            <= x0_nx;
      x_last        <= x_last_nx;
      y_last        <= y_last_nx;
      bus.xout      <= xout_nx;
      bus.yout      <= yout_nx;
      bus.colourout <= colour_nx;
      bus.plot      <= plot_nx;
      bus.busy      <= (state_nx != IDLE);
      bus.done      <= (state_nx == DONE);
`ifdef DRAW_OUTLINE_EN
      y0            <= y0_nx;
      outline       <= outline_nx;
`endif
    end
  end

  assign bus.req_ready = (state == IDLE);

endmodule

// File: tb/tb_block_draw_ctrl.sv
// Bench for block_draw_ctrl: scoreboard of expected pixels checked on every plot,
// plus per-scenario latency/count checks. Build with DRAW_OUTLINE_EN to add the outline scenario.
module tb_block_draw_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  block_draw_ctrl_if bus();
  block_draw_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   checks   = 0;
  int   passes   = 0;
  int   plot_cnt = 0;

  // Every plotted pixel must be the next one the model expects.
  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      pix_t got, exp;
      got = {bus.xout, bus.yout, bus.colourout};
      plot_cnt++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL pixel: got plot at (%0d,%0d) c=%0d, required no plot", bus.xout, bus.yout, bus.colourout);
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          $display("FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                   got.x, got.y, got.c, exp.x, exp.y, exp.c);
        else
          passes++;
      end
    end
  end

  // Reference model: clipped raster walk, optionally perimeter only.
  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input logic [2:0] c, input bit outline);
    int xl, yl;
    xl = ((x + w) < 160 ? (x + w) : 160) - 1;
    yl = ((y + h) < 120 ? (y + h) : 120) - 1;
    for (int yy = y; yy <= yl; yy++)
      for (int xx = x; xx <= xl; xx++)
        if (!outline || xx == x || xx == xl || yy == y || yy == yl)
          sb.push_back({8'(xx), 7'(yy), c});
  endtask

  // Presents a command at a negedge; returns just after the accept edge.
  task automatic send_rect(input int x, input int y, input int w, input int h,
                           input logic [2:0] c, input bit outline);
    @(negedge clk);
    bus.req_x      = 8'(x);
    bus.req_y      = 7'(y);
    bus.req_w      = 8'(w);
    bus.req_h      = 7'(h);
    bus.req_colour = c;
`ifdef DRAW_OUTLINE_EN
    bus.req_outline = outline;
`else
    if (outline) $display("note: outline requested in a build without it");
`endif
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_x      = 8'hAA;   // latched values must not follow the inputs
    bus.req_y      = 7'h55;
    bus.req_w      = 8'hFF;
    bus.req_colour = ~c;
  endtask

  // Counts negedges (first is accept+1) until done; -1 if it never comes.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.req_ready); else passes++;
    checks++; if (bus.plot !== 1'b0)      $display("FAIL reset_plot: got %b required 0", bus.plot); else passes++;
    checks++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy: got %b required 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0)      $display("FAIL reset_done: got %b required 0", bus.done); else passes++;
    checks++; if ({bus.xout, bus.yout, bus.colourout} !== 18'd0)
      $display("FAIL reset_pixel: got (%0d,%0d,%0d) required (0,0,0)", bus.xout, bus.yout, bus.colourout); else passes++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rect();
    int n;
    plot_cnt = 0;
    push_rect(10, 20, 3, 2, 3'b100, 1'b0);
    send_rect(10, 20, 3, 2, 3'b100, 1'b0);
    @(negedge clk);
    checks++; if (bus.plot !== 1'b1) $display("FAIL rect_first_plot: got %b required 1", bus.plot); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL rect_busy: got %b required 1", bus.busy); else passes++;
    wait_done(50, n);
    if (n > 0) n = n + 1;
    checks++; if (n !== 7) $display("FAIL rect_done_latency: got %0d required 7", n); else passes++;
    checks++; if (bus.req_ready !== 1'b0) $display("FAIL rect_ready_in_done: got %b required 0", bus.req_ready); else passes++;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL rect_ready_after: got %b required 1", bus.req_ready); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rect_done_pulse: got %b required 0", bus.done); else passes++;
    checks++; if (plot_cnt !== 6) $display("FAIL rect_plot_count: got %0d required 6", plot_cnt); else passes++;
    checks++; if (sb.size() !== 0) $display("FAIL rect_sb_left: got %0d required 0", sb.size()); else passes++;
    checks++; if ({bus.xout, bus.yout, bus.colourout} !== {8'd12, 7'd21, 3'd4})
      $display("FAIL rect_hold: got (%0d,%0d,%0d) required (12,21,4)", bus.xout, bus.yout, bus.colourout); else passes++;
  endtask

  task automatic test_clip();
    int n;
    plot_cnt = 0;
    push_rect(158, 119, 5, 4, 3'b010, 1'b0);
    send_rect(158, 119, 5, 4, 3'b010, 1'b0);
    wait_done(50, n);
    checks++; if (n !== 3) $display("FAIL clip_done_latency: got %0d required 3", n); else passes++;
    checks++; if (plot_cnt !== 2) $display("FAIL clip_plot_count: got %0d required 2", plot_cnt); else passes++;
    checks++; if (sb.size() !== 0) $display("FAIL clip_sb_left: got %0d required 0", sb.size()); else passes++;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int n;
    int xs[3] = '{10, 160, 20};
    int ws[3] = '{0, 4, 3};
    int hs[3] = '{2, 2, 0};
    for (int k = 0; k < 3; k++) begin
      plot_cnt = 0;
      send_rect(xs[k], 5, ws[k], hs[k], 3'b111, 1'b0);
      wait_done(20, n);
      checks++; if (n !== 1) $display("FAIL empty_done_latency[%0d]: got %0d required 1", k, n); else passes++;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL empty_ready[%0d]: got %b required 1", k, bus.req_ready); else passes++;
      checks++; if (plot_cnt !== 0) $display("FAIL empty_plot_count[%0d]: got %0d required 0", k, plot_cnt); else passes++;
    end
  endtask

  task automatic test_clear_priority();
    int n;
    plot_cnt = 0;
    push_rect(0, 0, 160, 120, 3'b000, 1'b0);
    push_rect(5, 6, 2, 2, 3'b011, 1'b0);
    @(negedge clk);
    bus.req_x = 8'd5; bus.req_y = 7'd6; bus.req_w = 8'd2; bus.req_h = 7'd2; bus.req_colour = 3'b011;
`ifdef DRAW_OUTLINE_EN
    bus.req_outline = 1'b0;
`endif
    bus.req_valid = 1'b1;
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    wait_done(20000, n);
    checks++; if (n !== 19201) $display("FAIL clear_done_latency: got %0d required 19201", n); else passes++;
    checks++; if (plot_cnt !== 19200) $display("FAIL clear_plot_count: got %0d required 19200", plot_cnt); else passes++;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL clear_pending_ready: got %b required 1", bus.req_ready); else passes++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done(50, n);
    checks++; if (n !== 5) $display("FAIL pending_done_latency: got %0d required 5", n); else passes++;
    checks++; if (plot_cnt !== 19204) $display("FAIL pending_plot_count: got %0d required 19204", plot_cnt); else passes++;
    checks++; if (sb.size() !== 0) $display("FAIL pending_sb_left: got %0d required 0", sb.size()); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    plot_cnt = 0;
    push_rect(30, 40, 4, 4, 3'b101, 1'b0);
    send_rect(30, 40, 4, 4, 3'b101, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.plot !== 1'b0) $display("FAIL abort_plot: got %b required 0", bus.plot); else passes++;
    checks++; if ({bus.busy, bus.done, bus.req_ready} !== 3'b001)
      $display("FAIL abort_flags: got busy=%b done=%b ready=%b required 0 0 1", bus.busy, bus.done, bus.req_ready); else passes++;
    checks++; if ({bus.xout, bus.yout, bus.colourout} !== 18'd0)
      $display("FAIL abort_pixel: got (%0d,%0d,%0d) required (0,0,0)", bus.xout, bus.yout, bus.colourout); else passes++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (plot_cnt !== 3) $display("FAIL abort_plot_count: got %0d required 3", plot_cnt); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", bus.busy); else passes++;
    sb.delete();
  endtask

`ifdef DRAW_OUTLINE_EN
  task automatic test_outline();
    int n;
    plot_cnt = 0;
    push_rect(0, 0, 4, 3, 3'b010, 1'b1);
    send_rect(0, 0, 4, 3, 3'b010, 1'b1);
    wait_done(50, n);
    checks++; if (n !== 13) $display("FAIL outline_done_latency: got %0d required 13", n); else passes++;
    checks++; if (plot_cnt !== 10) $display("FAIL outline_plot_count: got %0d required 10", plot_cnt); else passes++;
    checks++; if (sb.size() !== 0) $display("FAIL outline_sb_left: got %0d required 0", sb.size()); else passes++;
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.req_valid  = 1'b0;
    bus.clear_req  = 1'b0;
    bus.req_x      = 8'd0;
    bus.req_y      = 7'd0;
    bus.req_w      = 8'd0;
    bus.req_h      = 7'd0;
    bus.req_colour = 3'd0;
`ifdef DRAW_OUTLINE_EN
    bus.req_outline = 1'b0;
`endif
    test_reset();
    test_rect();
    test_clip();
    test_empty();
    test_clear_priority();
    test_reset_abort();
`ifdef DRAW_OUTLINE_EN
    test_outline();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
